// File: rtl/div_seq_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package div_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int unsigned DEFAULT_BITS  = 4;
    localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_BITS);

    // Width of the iteration counter, which must hold BITS-1.
    function automatic int unsigned cnt_width(input int unsigned bits);
        return $clog2(bits);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, compare, subtract.
module div_step #(
    parameter int unsigned BITS = 4
) (
    input  logic [BITS-1:0] partial_rem,
    input  logic            next_bit,
    input  logic [BITS-1:0] divisor,
    output logic [BITS-1:0] new_rem,
    output logic            q_bit
);

    logic [BITS:0]   tmp;
    logic [BITS-1:0] diff;

    always_comb begin
        tmp   = {partial_rem, next_bit};
        q_bit = (tmp >= {1'b0, divisor});
        // When the subtraction is taken the result is below divisor, so the low BITS suffice.
        diff    = tmp[BITS-1:0] - divisor;
        new_rem = q_bit ? diff : tmp[BITS-1:0];
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider with valid/ready request and response channels.
// Optional macro DIV_SEQUENCER_SHORTCUT_EN: zero divisor or dividend<divisor completes at the accept edge.
module div_sequencer
    import div_seq_pkg::*;
#(
    parameter int unsigned BITS = DEFAULT_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [BITS-1:0] req_dividend,
    input  logic [BITS-1:0] req_divisor,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [BITS-1:0] rsp_quotient,
    output logic [BITS-1:0] rsp_remainder,
    output logic            rsp_div_by_zero,
    output logic            busy
);

    localparam int unsigned CNT_W = cnt_width(BITS);

    state_t          state;
    logic [BITS-1:0] q_sr;
    logic [BITS-1:0] rem;
    logic [BITS-1:0] divisor_r;
    logic [CNT_W-1:0] cnt;
    logic            dbz;
    logic [BITS-1:0] new_rem;
    logic            q_bit;

    div_step #(
        .BITS(BITS)
    ) u_step (
        .partial_rem(rem),
        .next_bit   (q_sr[BITS-1]),
        .divisor    (divisor_r),
        .new_rem    (new_rem),
        .q_bit      (q_bit)
    );

    // The working registers double as the result registers once DONE is reached.
    assign rsp_quotient    = q_sr;
    assign rsp_remainder   = rem;
    assign rsp_div_by_zero = dbz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            q_sr      <= '0;
            rem       <= '0;
            divisor_r <= '0;
            cnt       <= '0;
            dbz       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        divisor_r <= req_divisor;
                        q_sr      <= req_dividend;
                        rem       <= '0;
                        cnt       <= CNT_W'(BITS - 1);
                        dbz       <= (req_divisor == '0);
                        req_ready <= 1'b0;
`ifdef DIV_SEQUENCER_SHORTCUT_EN
                        if ((req_divisor == '0) || (req_dividend < req_divisor)) begin
                            q_sr      <= {BITS{req_divisor == '0}};
                            rem       <= req_dividend;
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                        end
`else
                        state <= CALC;
                        busy  <= 1'b1;
`endif
                    end
                end
                CALC: begin
                    q_sr <= {q_sr[BITS-2:0], q_bit};
                    rem  <= new_rem;
                    if (cnt == '0) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_valid && rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
